byte_packer: RTL and testbench
==============================

# byte_packer

Receive-side companion to the transmit word-to-byte converter. Accepts one byte per valid cycle and reassembles it into 32-, 16- or 8-bit words, using the same PCLK width code and MODO override as the transmit path. Byte order matches the transmit path: the first byte of a word is its most significant byte. Sits directly downstream of the byte lane and feeds the PIPE-side word interface.

## Interface
- No parameters. Byte width is fixed at 8 and word width at 32.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- PCLK  in  2  width code: 00 = 32 bits, 01 = 16 bits, 10 = 8 bits, 11 = invalid.
- MODO  in  1  when 1, forces 32-bit width regardless of PCLK.
- in_8  in  8  incoming byte.
- valid_in  in  1  in_8 is valid this cycle.
- flush  in  1  discards any partial word.
- out_32  out  32  assembled word; unused upper bits are zero.
- valid_out  out  1  one-cycle pulse when out_32 is updated.
- err  out  1  one-cycle pulse when a byte is dropped.

## Operation
- Effective width code W:
  - 32 if MODO = 1, or if PCLK = 00.
  - 16 if PCLK = 01.
  - 8 if PCLK = 10.
  - Invalid if PCLK = 11 and MODO = 0.
- Bytes per word N = 4, 2 or 1 for W = 32, 16, 8.
- State machine IDLE/FILL, with a 2-bit byte counter cnt, a latched width wl and a 32-bit accumulator acc.
- IDLE, on valid_in with W valid:
  - Latch wl = W and store the byte.
  - If N = 1, emit the word and stay in IDLE.
  - Otherwise set cnt = 1 and go to FILL.
- FILL, on valid_in:
  - Store the byte at position cnt and increment cnt.
  - When cnt reaches N−1 with a valid byte, emit the word and return to IDLE.
- Byte placement:
  - 32-bit: byte k goes to bits [31−8k : 24−8k].
  - 16-bit: byte 0 goes to [15:8] and byte 1 to [7:0]; bits [31:16] = 0.
  - 8-bit: the byte goes to [7:0]; bits [31:8] = 0.
- Emit: out_32 takes the completed word (the final byte merged in the same edge), and valid_out = 1 for that cycle only.
- Width changes on PCLK or MODO while in FILL are ignored. The word completes with wl, and the new width applies from the next first byte.
- Invalid W in IDLE with valid_in: the byte is dropped, err pulses, and the state stays IDLE.
- flush = 1: the state goes to IDLE, cnt = 0 and acc = 0, and any byte presented the same cycle is discarded. No valid_out and no err. flush has priority over valid_in.
- valid_in = 0 in FILL: hold state; gaps of any length are allowed.

## Timing
- Reset values: out_32 = 0, valid_out = 0, err = 0, state = IDLE, cnt = 0, acc = 0, wl = 32.
- Reset asserted mid-word discards the partial word immediately (asynchronous).
- Latency: valid_out rises on the clock edge that samples the final byte of a word. out_32 is visible in the following cycle, one cycle after the last byte is presented.
- out_32 holds its value between valid_out pulses.
- Back-to-back throughput is one word per N valid cycles with no bubble: a word's last byte and the next word's first byte may be on consecutive cycles.
- err is registered and appears in the cycle after the dropped byte.

## Structure
- Shared package holds:
  - the width codes W32 = 2'b00, W16 = 2'b01, W8 = 2'b10, WINV = 2'b11;
  - the state encodings IDLE and FILL;
  - a function mapping a width code to N.
- The transmit converter uses the same package.
- One natural sub-module, byte_packer_lane_sel: combinational W/N decode from PCLK and MODO, shared with the transmit side.
- Everything else stays flat in byte_packer.

## Test plan
- 32-bit, no gaps: PCLK = 00, MODO = 0, bytes AA, BB, CC, DD. Expect out_32 = AABBCCDD and one valid_out pulse, on the edge of DD.
- 16-bit with gap: PCLK = 01, bytes 12, (two idle cycles), 34. Expect out_32 = 00001234 and one valid_out.
- 8-bit stream with MODO override:
  - PCLK = 10, bytes 5A, A5. Expect two pulses: 0000005A, then 000000A5.
  - Then MODO = 1, bytes 01 02 03 04. Expect 01020304.
- Mid-word width change and flush:
  - PCLK = 00, bytes 11, 22; PCLK → 10; bytes 33, 44. Expect 11223344.
  - Then bytes 55, 66, flush, then 77 at PCLK = 10. Expect only 00000077.
- Invalid mode and reset:
  - PCLK = 11, MODO = 0, byte EE. Expect an err pulse, no valid_out, out_32 unchanged.
  - reset_L low after two bytes of a 32-bit word. Expect all outputs 0 at once, and the next four bytes form a fresh word.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte lane converters: width codes, FSM states,
// and the helpers that map a width code to bytes-per-word and byte position.
package byte_packer_pkg;

  typedef enum logic [1:0] {
    W32  = 2'b00,
    W16  = 2'b01,
    W8   = 2'b10,
    WINV = 2'b11
  } width_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic logic [2:0] bytes_per_word(input width_t w);
    case (w)
      W32:     bytes_per_word = 3'd4;
      W16:     bytes_per_word = 3'd2;
      W8:      bytes_per_word = 3'd1;
      default: bytes_per_word = 3'd0;
    endcase
  endfunction

  // First byte of a word is the most significant byte of the used width;
  // the accumulator is always cleared on byte 0, so OR-merging is safe.
  function automatic logic [31:0] place_byte(input logic [31:0] acc,
                                             input logic [7:0]  b,
                                             input width_t      w,
                                             input logic [1:0]  idx);
    logic [1:0] sh;
    case (w)
      W32:     sh = 2'd3 - idx;
      W16:     sh = {1'b0, ~idx[0]};
      default: sh = 2'd0;
    endcase
    place_byte = acc | ({24'd0, b} << {sh, 3'b000});
  endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte-in / word-out bus between the byte lane and the PIPE-side word port.
interface byte_packer_if;
  logic [1:0]  PCLK;
  logic        MODO;
  logic [7:0]  in_8;
  logic        valid_in;
  logic        flush;
  logic [31:0] out_32;
  logic        valid_out;
  logic        err;

  modport master (
    output PCLK, MODO, in_8, valid_in, flush,
    input  out_32, valid_out, err
  );

  modport slave (
    input  PCLK, MODO, in_8, valid_in, flush,
    output out_32, valid_out, err
  );
endinterface

// File: rtl/byte_packer_lane_sel.sv
// Width decode from PCLK/MODO, shared by the transmit and receive converters.
module byte_packer_lane_sel
  import byte_packer_pkg::*;
(
  input  logic [1:0] i_pclk,
  input  logic       i_modo,
  output width_t     o_width,
  output logic [2:0] o_nbytes,
  output logic       o_valid
);

  always_comb begin
    o_width = W32;
    if (!i_modo) o_width = width_t'(i_pclk);
    o_valid  = (o_width != WINV);
    o_nbytes = bytes_per_word(o_width);
  end

endmodule

// File: rtl/byte_packer.sv
// Receive-side byte-to-word packer: gathers 1, 2 or 4 bytes (MSB first)
// into a 32-bit word, with flush, drop-on-invalid-width and registered outputs.
module byte_packer
  import byte_packer_pkg::*;
(
  input  logic          clk,
  input  logic          reset_L,
  byte_packer_if.slave  bus
);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  width_t      r_wl, w_wl_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [31:0] r_out, w_out_nxt;
  logic        r_vld, r_err;
  logic        w_emit, w_drop;

  width_t      w_width;
  logic [2:0]  w_nbytes;
  logic        w_wvalid;
  logic        w_last_fill;

  byte_packer_lane_sel u_lane_sel (
    .i_pclk   (bus.PCLK),
    .i_modo   (bus.MODO),
    .o_width  (w_width),
    .o_nbytes (w_nbytes),
    .o_valid  (w_wvalid)
  );

  // In FILL the word length comes from the latched width, not the live inputs.
  assign w_last_fill = ({1'b0, r_cnt} == (bytes_per_word(r_wl) - 3'd1));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_wl    <= W32;
      r_acc   <= 32'd0;
      r_out   <= 32'd0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wl    <= w_wl_nxt;
      r_acc   <= w_acc_nxt;
      r_out   <= w_out_nxt;
      r_vld   <= w_emit;
      r_err   <= w_drop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else if (bus.valid_in) begin
      case (r_state)
        IDLE: if (w_wvalid && (w_nbytes != 3'd1)) w_state_nxt = FILL;
        FILL: if (w_last_fill) w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wl_nxt  = r_wl;
    w_acc_nxt = r_acc;
    w_out_nxt = r_out;
    w_emit    = 1'b0;
    w_drop    = 1'b0;
    if (bus.flush) begin
      w_cnt_nxt = 2'd0;
      w_acc_nxt = 32'd0;
    end else if (bus.valid_in) begin
      case (r_state)
        IDLE: begin
          if (!w_wvalid) begin
            w_drop = 1'b1;
          end else begin
            w_wl_nxt  = w_width;
            w_acc_nxt = place_byte(32'd0, bus.in_8, w_width, 2'd0);
            if (w_nbytes == 3'd1) begin
              w_emit    = 1'b1;
              w_out_nxt = w_acc_nxt;
              w_cnt_nxt = 2'd0;
            end else begin
              w_cnt_nxt = 2'd1;
            end
          end
        end
        FILL: begin
          w_acc_nxt = place_byte(r_acc, bus.in_8, r_wl, r_cnt);
          if (w_last_fill) begin
            w_emit    = 1'b1;
            w_out_nxt = w_acc_nxt;
            w_cnt_nxt = 2'd0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.out_32    = r_out;
  assign bus.valid_out = r_vld;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: hand-computed words for each width mode,
// gaps, mid-word width change, flush, invalid width and async reset.
module tb_byte_packer;

  logic clk;
  logic reset_L;
  int   total;
  int   bad;

  byte_packer_if bus ();

  byte_packer dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, then sample just after the rising edge.
  task automatic step(input logic v, input logic [7:0] b, input logic fl);
    @(negedge clk);
    bus.valid_in = v;
    bus.in_8     = b;
    bus.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_L      = 1'b0;
    bus.PCLK     = 2'b00;
    bus.MODO     = 1'b0;
    bus.in_8     = 8'h00;
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", bus.out_32, 32'h0);
    chk("rst_vld", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    reset_L = 1'b1;

    // 32-bit, no gaps
    bus.PCLK = 2'b00;
    send(8'hAA); chk("w32_b0_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'hBB); chk("w32_b1_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'hCC); chk("w32_b2_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'hDD); chk("w32_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("w32_out", bus.out_32, 32'hAABBCCDD);
    idle();
    chk("w32_pulse_end", {31'd0, bus.valid_out}, 32'd0);
    chk("w32_hold", bus.out_32, 32'hAABBCCDD);

    // 16-bit with a two-cycle gap
    bus.PCLK = 2'b01;
    send(8'h12); chk("w16_b0_vld", {31'd0, bus.valid_out}, 32'd0);
    idle(); idle();
    chk("w16_gap_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'h34); chk("w16_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("w16_out", bus.out_32, 32'h00001234);

    // 8-bit back-to-back, then MODO forces 32-bit
    bus.PCLK = 2'b10;
    send(8'h5A); chk("w8a_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("w8a_out", bus.out_32, 32'h0000005A);
    send(8'hA5); chk("w8b_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("w8b_out", bus.out_32, 32'h000000A5);
    bus.MODO = 1'b1;
    send(8'h01); chk("modo_b0_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'h02);
    send(8'h03); chk("modo_b2_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'h04); chk("modo_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("modo_out", bus.out_32, 32'h01020304);
    bus.MODO = 1'b0;

    // Width change mid-word is ignored until the word completes
    bus.PCLK = 2'b00;
    send(8'h11); send(8'h22);
    bus.PCLK = 2'b10;
    send(8'h33); chk("wchg_b2_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'h44); chk("wchg_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("wchg_out", bus.out_32, 32'h11223344);

    // Flush discards the partial word and the byte presented with it
    bus.PCLK = 2'b00;
    send(8'h55); send(8'h66);
    step(1'b1, 8'h99, 1'b1);
    chk("flush_vld", {31'd0, bus.valid_out}, 32'd0);
    chk("flush_err", {31'd0, bus.err}, 32'd0);
    chk("flush_hold", bus.out_32, 32'h11223344);
    bus.PCLK = 2'b10;
    send(8'h77); chk("post_flush_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("post_flush_out", bus.out_32, 32'h00000077);

    // Invalid width drops the byte
    bus.PCLK = 2'b11;
    send(8'hEE);
    chk("inv_err", {31'd0, bus.err}, 32'd1);
    chk("inv_vld", {31'd0, bus.valid_out}, 32'd0);
    chk("inv_hold", bus.out_32, 32'h00000077);
    idle();
    chk("inv_err_pulse", {31'd0, bus.err}, 32'd0);

    // Asynchronous reset mid-word, then a fresh word
    bus.PCLK = 2'b00;
    send(8'hC1); send(8'hC2);
    bus.valid_in = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk("arst_out", bus.out_32, 32'h0);
    chk("arst_vld", {31'd0, bus.valid_out}, 32'd0);
    chk("arst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    send(8'hD1); send(8'hD2);
    send(8'hD3); chk("fresh_b2_vld", {31'd0, bus.valid_out}, 32'd0);
    send(8'hD4); chk("fresh_vld", {31'd0, bus.valid_out}, 32'd1);
    chk("fresh_out", bus.out_32, 32'hD1D2D3D4);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
